// File: rtl/ws2812_pkg.sv
// Shared WS2812 line-state encoding and default 50 MHz timing constants
// (used by the strip driver, this receiver and its bench).
package ws2812_pkg;

   typedef enum logic [1:0] {
      SYNC,
      IDLE,
      HIGH,
      LOW
   } state_t;

   localparam int DEF_T0H             = 18;
   localparam int DEF_T0L             = 45;
   localparam int DEF_T1H             = 35;
   localparam int DEF_T1L             = 28;
   localparam int DEF_BIT_PERIOD      = 63;
   localparam int DEF_RESET_CYCLES    = 2500;
   localparam int DEF_BIT_THRESHOLD   = 27;
   localparam int DEF_MAX_HIGH_CYCLES = 100;

endpackage

// File: rtl/ws2812_receiver_if.sv
// Receiver output bus: BRAM write port plus per-frame status.
interface ws2812_receiver_if #(
   parameter int ADDRESS_WIDTH = 13
);
   logic                     mem_we;
   logic [ADDRESS_WIDTH-1:0] mem_addr;
   logic [7:0]               mem_din;
   logic                     frame_done;
   logic [ADDRESS_WIDTH:0]   frame_bytes;
   logic                     frame_error;
   logic                     busy;

   modport master (
      output mem_we, mem_addr, mem_din, frame_done, frame_bytes, frame_error, busy
   );

   modport slave (
      input mem_we, mem_addr, mem_din, frame_done, frame_bytes, frame_error, busy
   );
endinterface

// File: rtl/ws2812_bit_decoder.sv
// Synchronises the WS2812 line and measures pulse widths, emitting one
// strobe per decoded bit, frame latch, line error and first-edge activity.
module ws2812_bit_decoder
   import ws2812_pkg::*;
#(
   parameter int BIT_THRESHOLD   = DEF_BIT_THRESHOLD,
   parameter int MAX_HIGH_CYCLES = DEF_MAX_HIGH_CYCLES,
   parameter int RESET_CYCLES    = DEF_RESET_CYCLES
) (
   input  logic clk,
   input  logic rst,
   input  logic strip_in,
   output logic bit_valid,
   output logic bit_value,
   output logic frame_end,
   output logic line_error,
   output logic activity
);
   localparam int LOW_W  = $clog2(RESET_CYCLES + 1);
   localparam int HIGH_W = $clog2(MAX_HIGH_CYCLES + 2);

   localparam logic [LOW_W-1:0]  LOW_TERM = LOW_W'(RESET_CYCLES - 1);
   localparam logic [HIGH_W-1:0] HIGH_MAX = HIGH_W'(MAX_HIGH_CYCLES);
   localparam logic [HIGH_W-1:0] HIGH_SAT = HIGH_W'(MAX_HIGH_CYCLES + 1);
   localparam logic [HIGH_W-1:0] HIGH_THR = HIGH_W'(BIT_THRESHOLD);

   logic [1:0]        sync_q;
   logic              line;
   state_t            state_q, state_d;
   logic [HIGH_W-1:0] high_q, high_d;
   logic [LOW_W-1:0]  low_q, low_d;

   assign line = sync_q[1];

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q  <= '0;
         state_q <= SYNC;
         high_q  <= '0;
         low_q   <= '0;
      end else begin
         sync_q  <= {sync_q[0], strip_in};
         state_q <= state_d;
         high_q  <= high_d;
         low_q   <= low_d;
      end
   end

   // The current cycle counts toward the low run, so terminal count is
   // detected one below RESET_CYCLES on the registered value.
   always_comb begin
      state_d    = state_q;
      high_d     = high_q;
      low_d      = low_q;
      bit_valid  = 1'b0;
      bit_value  = (high_q >= HIGH_THR);
      frame_end  = 1'b0;
      line_error = 1'b0;
      activity   = 1'b0;
      case (state_q)
         SYNC: begin
            if (line) begin
               low_d = '0;
            end else if (low_q == LOW_TERM) begin
               frame_end = 1'b1;
               low_d     = '0;
               state_d   = IDLE;
            end else begin
               low_d = low_q + LOW_W'(1);
            end
         end
         IDLE: begin
            if (line) begin
               activity = 1'b1;
               high_d   = HIGH_W'(1);
               state_d  = HIGH;
            end
         end
         HIGH: begin
            if (high_q > HIGH_MAX) begin
               line_error = 1'b1;
               high_d     = '0;
               low_d      = '0;
               state_d    = SYNC;
            end else if (!line) begin
               bit_valid = 1'b1;
               low_d     = LOW_W'(1);
               state_d   = LOW;
            end else if (high_q != HIGH_SAT) begin
               high_d = high_q + HIGH_W'(1);
            end
         end
         LOW: begin
            if (line) begin
               high_d  = HIGH_W'(1);
               state_d = HIGH;
            end else if (low_q == LOW_TERM) begin
               frame_end = 1'b1;
               low_d     = '0;
               state_d   = IDLE;
            end else begin
               low_d = low_q + LOW_W'(1);
            end
         end
         default: state_d = SYNC;
      endcase
   end

endmodule

// File: rtl/ws2812_receiver.sv
// WS2812 stream receiver: assembles decoded bits MSB-first into bytes,
// writes them to consecutive BRAM addresses and reports per-frame status.
module ws2812_receiver
   import ws2812_pkg::*;
#(
   parameter int ADDRESS_WIDTH   = 13,
   parameter int BASE_ADDRESS    = 0,
   parameter int NUM_BYTES       = 8192,
   parameter int BIT_THRESHOLD   = DEF_BIT_THRESHOLD,
   parameter int MAX_HIGH_CYCLES = DEF_MAX_HIGH_CYCLES,
   parameter int RESET_CYCLES    = DEF_RESET_CYCLES
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               strip_in,
   ws2812_receiver_if.master  bus
);
   logic bit_valid, bit_value, frame_end, line_error, activity;

   logic                     mem_we_q;
   logic [ADDRESS_WIDTH-1:0] mem_addr_q;
   logic [7:0]               mem_din_q;
   logic                     frame_done_q;
   logic [ADDRESS_WIDTH:0]   frame_bytes_q;
   logic                     frame_error_q;
   logic                     busy_q;
   logic                     err_q;
   logic [2:0]               bit_idx_q;
   logic [6:0]               shift_q;
   logic [ADDRESS_WIDTH:0]   byte_idx_q;

   ws2812_bit_decoder #(
      .BIT_THRESHOLD   (BIT_THRESHOLD),
      .MAX_HIGH_CYCLES (MAX_HIGH_CYCLES),
      .RESET_CYCLES    (RESET_CYCLES)
   ) u_dec (
      .clk        (clk),
      .rst        (rst),
      .strip_in   (strip_in),
      .bit_valid  (bit_valid),
      .bit_value  (bit_value),
      .frame_end  (frame_end),
      .line_error (line_error),
      .activity   (activity)
   );

   // Bytes past NUM_BYTES still advance the count (for frame_bytes) but
   // are not written.
   always_ff @(posedge clk) begin
      if (rst) begin
         mem_we_q      <= 1'b0;
         mem_addr_q    <= '0;
         mem_din_q     <= '0;
         frame_done_q  <= 1'b0;
         frame_bytes_q <= '0;
         frame_error_q <= 1'b0;
         busy_q        <= 1'b0;
         err_q         <= 1'b0;
         bit_idx_q     <= '0;
         shift_q       <= '0;
         byte_idx_q    <= '0;
      end else begin
         mem_we_q     <= 1'b0;
         frame_done_q <= 1'b0;
         if (activity) busy_q <= 1'b1;
         if (line_error) begin
            err_q     <= 1'b1;
            bit_idx_q <= '0;
         end
         if (bit_valid) begin
            shift_q <= {shift_q[5:0], bit_value};
            if (bit_idx_q == 3'd7) begin
               bit_idx_q <= '0;
               if (byte_idx_q != '1) byte_idx_q <= byte_idx_q + 1'b1;
               if (int'(byte_idx_q) < NUM_BYTES) begin
                  mem_we_q   <= 1'b1;
                  mem_addr_q <= ADDRESS_WIDTH'(BASE_ADDRESS) + byte_idx_q[ADDRESS_WIDTH-1:0];
                  mem_din_q  <= {shift_q, bit_value};
               end else begin
                  err_q <= 1'b1;
               end
            end else begin
               bit_idx_q <= bit_idx_q + 3'd1;
            end
         end
         if (frame_end && busy_q) begin
            frame_done_q  <= 1'b1;
            frame_bytes_q <= byte_idx_q;
            frame_error_q <= err_q | (bit_idx_q != 3'd0);
            byte_idx_q    <= '0;
            bit_idx_q     <= '0;
            err_q         <= 1'b0;
            busy_q        <= 1'b0;
         end
      end
   end

   assign bus.mem_we      = mem_we_q;
   assign bus.mem_addr    = mem_addr_q;
   assign bus.mem_din     = mem_din_q;
   assign bus.frame_done  = frame_done_q;
   assign bus.frame_bytes = frame_bytes_q;
   assign bus.frame_error = frame_error_q;
   assign bus.busy        = busy_q;

endmodule

// File: tb/tb_ws2812_receiver.sv
// Directed bench for ws2812_receiver: one default instance and one with
// BASE_ADDRESS=100/NUM_BYTES=2, both fed from the same line.
module tb_ws2812_receiver;
   import ws2812_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic strip = 1'b0;

   always #5 clk = ~clk;

   ws2812_receiver_if #(.ADDRESS_WIDTH(13)) bus_a ();
   ws2812_receiver_if #(.ADDRESS_WIDTH(13)) bus_b ();

   ws2812_receiver #(.ADDRESS_WIDTH(13)) dut_a (
      .clk      (clk),
      .rst      (rst),
      .strip_in (strip),
      .bus      (bus_a)
   );

   ws2812_receiver #(.ADDRESS_WIDTH(13), .BASE_ADDRESS(100), .NUM_BYTES(2)) dut_b (
      .clk      (clk),
      .rst      (rst),
      .strip_in (strip),
      .bus      (bus_b)
   );

   int total = 0;
   int bad   = 0;

   // Captured writes {addr, data} and frames {error, bytes}
   logic [20:0] qa[$];
   logic [20:0] qb[$];
   logic [14:0] fa[$];
   logic [14:0] fb[$];

   always @(negedge clk) begin
      if (bus_a.mem_we)     qa.push_back({bus_a.mem_addr, bus_a.mem_din});
      if (bus_b.mem_we)     qb.push_back({bus_b.mem_addr, bus_b.mem_din});
      if (bus_a.frame_done) fa.push_back({bus_a.frame_error, bus_a.frame_bytes});
      if (bus_b.frame_done) fb.push_back({bus_b.frame_error, bus_b.frame_bytes});
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [20:0] wr_at(input logic [20:0] q[$], input int i);
      return (i < q.size()) ? q[i] : 'x;
   endfunction

   function automatic logic [14:0] fr_at(input logic [14:0] q[$], input int i);
      return (i < q.size()) ? q[i] : 'x;
   endfunction

   task automatic clr();
      qa.delete(); qb.delete(); fa.delete(); fb.delete();
   endtask

   task automatic drive(input logic v, input int n);
      strip = v;
      repeat (n) @(negedge clk);
   endtask

   task automatic send_bit(input logic b, input int t1h, input int t0h, input int low);
      drive(1'b1, b ? t1h : t0h);
      drive(1'b0, low);
   endtask

   task automatic send_byte(input logic [7:0] d, input int t1h, input int t0h, input int last_low);
      for (int i = 7; i >= 0; i--)
         send_bit(d[i], t1h, t0h, (i == 0) ? last_low : (d[i] ? DEF_T1L : DEF_T0L));
   endtask

   typedef struct {
      logic [7:0] data;
      int         t1h;
      int         t0h;
      logic [7:0] exp;
   } vec_t;

   vec_t tbl[6];

   initial begin
      tbl[0] = '{8'hA5, DEF_T1H, DEF_T0H, 8'hA5};
      tbl[1] = '{8'hFF, 27,      DEF_T0H, 8'hFF};
      tbl[2] = '{8'h00, DEF_T1H, 26,      8'h00};
      tbl[3] = '{8'hFF, 26,      DEF_T0H, 8'h00};
      tbl[4] = '{8'h00, DEF_T1H, 27,      8'hFF};
      tbl[5] = '{8'h6E, 27,      26,      8'h6E};

      // Reset state
      rst = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_we",    {31'd0, bus_a.mem_we},      32'd0);
      chk("rst_addr",  {19'd0, bus_a.mem_addr},    32'd0);
      chk("rst_din",   {24'd0, bus_a.mem_din},     32'd0);
      chk("rst_done",  {31'd0, bus_a.frame_done},  32'd0);
      chk("rst_bytes", {18'd0, bus_a.frame_bytes}, 32'd0);
      chk("rst_err",   {31'd0, bus_a.frame_error}, 32'd0);
      chk("rst_busy",  {31'd0, bus_a.busy},        32'd0);
      rst = 1'b0;
      drive(1'b0, 2600);
      chk("idle_no_frame", fa.size(), 0);
      chk("idle_no_write", qa.size(), 0);

      // Single-byte frames including high-time thresholds
      for (int v = 0; v < 6; v++) begin
         clr();
         send_byte(tbl[v].data, tbl[v].t1h, tbl[v].t0h, 40);
         drive(1'b0, 2600);
         chk($sformatf("v%0d_nwr", v),  qa.size(), 1);
         chk($sformatf("v%0d_wr", v),   wr_at(qa, 0), {13'd0, tbl[v].exp});
         chk($sformatf("v%0d_nfr", v),  fa.size(), 1);
         chk($sformatf("v%0d_fr", v),   fr_at(fa, 0), {1'b0, 14'd1});
         chk($sformatf("v%0d_wr_b", v), wr_at(qb, 0), {13'd100, tbl[v].exp});
         chk($sformatf("v%0d_fr_b", v), fr_at(fb, 0), {1'b0, 14'd1});
      end

      // Two-byte frame
      clr();
      send_byte(8'hA5, DEF_T1H, DEF_T0H, DEF_T0L);
      send_byte(8'h3C, DEF_T1H, DEF_T0H, DEF_T0L);
      drive(1'b0, 2600);
      chk("two_nwr", qa.size(), 2);
      chk("two_wr0", wr_at(qa, 0), {13'd0, 8'hA5});
      chk("two_wr1", wr_at(qa, 1), {13'd1, 8'h3C});
      chk("two_fr",  fr_at(fa, 0), {1'b0, 14'd2});
      chk("two_bytes_held", {18'd0, bus_a.frame_bytes}, 32'd2);
      chk("two_err_held",   {31'd0, bus_a.frame_error}, 32'd0);
      chk("two_busy",       {31'd0, bus_a.busy},        32'd0);

      // Overflow beyond NUM_BYTES on dut_b
      clr();
      send_byte(8'h11, DEF_T1H, DEF_T0H, DEF_T0L);
      send_byte(8'h22, DEF_T1H, DEF_T0H, DEF_T0L);
      send_byte(8'h33, DEF_T1H, DEF_T0H, DEF_T0L);
      drive(1'b0, 2600);
      chk("ovf_nwr_b", qb.size(), 2);
      chk("ovf_wr0_b", wr_at(qb, 0), {13'd100, 8'h11});
      chk("ovf_wr1_b", wr_at(qb, 1), {13'd101, 8'h22});
      chk("ovf_fr_b",  fr_at(fb, 0), {1'b1, 14'd3});
      chk("ovf_nwr_a", qa.size(), 3);
      chk("ovf_fr_a",  fr_at(fa, 0), {1'b0, 14'd3});

      // 12 bits: partial trailing byte
      clr();
      send_byte(8'hC3, DEF_T1H, DEF_T0H, DEF_T0L);
      send_bit(1'b1, DEF_T1H, DEF_T0H, DEF_T1L);
      send_bit(1'b0, DEF_T1H, DEF_T0H, DEF_T0L);
      send_bit(1'b1, DEF_T1H, DEF_T0H, DEF_T1L);
      send_bit(1'b0, DEF_T1H, DEF_T0H, DEF_T0L);
      drive(1'b0, 2600);
      chk("part_nwr", qa.size(), 1);
      chk("part_wr",  wr_at(qa, 0), {13'd0, 8'hC3});
      chk("part_fr",  fr_at(fa, 0), {1'b1, 14'd1});

      // Over-long high pulse mid-byte, then a clean frame
      clr();
      send_byte(8'h77, DEF_T1H, DEF_T0H, DEF_T0L);
      send_bit(1'b1, DEF_T1H, DEF_T0H, DEF_T1L);
      send_bit(1'b0, DEF_T1H, DEF_T0H, DEF_T0L);
      send_bit(1'b1, DEF_T1H, DEF_T0H, DEF_T1L);
      drive(1'b1, 150);
      drive(1'b0, 2600);
      chk("glitch_nwr", qa.size(), 1);
      chk("glitch_wr",  wr_at(qa, 0), {13'd0, 8'h77});
      chk("glitch_nfr", fa.size(), 1);
      chk("glitch_fr",  fr_at(fa, 0), {1'b1, 14'd1});
      clr();
      send_byte(8'h5A, DEF_T1H, DEF_T0H, 40);
      drive(1'b0, 2600);
      chk("recover_wr", wr_at(qa, 0), {13'd0, 8'h5A});
      chk("recover_fr", fr_at(fa, 0), {1'b0, 14'd1});

      // Low gap of RESET_CYCLES-1 keeps the frame open
      clr();
      send_byte(8'hF0, DEF_T1H, DEF_T0H, 2499);
      send_byte(8'h0F, DEF_T1H, DEF_T0H, 40);
      drive(1'b0, 2600);
      chk("gap2499_nfr", fa.size(), 1);
      chk("gap2499_fr",  fr_at(fa, 0), {1'b0, 14'd2});
      chk("gap2499_wr1", wr_at(qa, 1), {13'd1, 8'h0F});

      // Low gap of exactly RESET_CYCLES closes it
      clr();
      send_byte(8'hF0, DEF_T1H, DEF_T0H, 2500);
      send_byte(8'h0F, DEF_T1H, DEF_T0H, 40);
      drive(1'b0, 2600);
      chk("gap2500_nfr", fa.size(), 2);
      chk("gap2500_fr0", fr_at(fa, 0), {1'b0, 14'd1});
      chk("gap2500_fr1", fr_at(fa, 1), {1'b0, 14'd1});
      chk("gap2500_wr1", wr_at(qa, 1), {13'd0, 8'h0F});

      // Reset asserted and released mid-transmission
      clr();
      send_bit(1'b1, DEF_T1H, DEF_T0H, DEF_T1L);
      send_bit(1'b0, DEF_T1H, DEF_T0H, DEF_T0L);
      rst = 1'b1;
      drive(1'b1, 5);
      chk("midrst_bytes", {18'd0, bus_a.frame_bytes}, 32'd0);
      chk("midrst_busy",  {31'd0, bus_a.busy},        32'd0);
      rst = 1'b0;
      drive(1'b1, 10);
      drive(1'b0, DEF_T1L);
      send_byte(8'h34, DEF_T1H, DEF_T0H, DEF_T0L);
      send_byte(8'h56, DEF_T1H, DEF_T0H, 40);
      drive(1'b0, 2600);
      chk("midrst_nwr", qa.size(), 0);
      chk("midrst_nfr", fa.size(), 0);
      send_byte(8'h3C, DEF_T1H, DEF_T0H, 40);
      drive(1'b0, 2600);
      chk("midrst_after_wr", wr_at(qa, 0), {13'd0, 8'h3C});
      chk("midrst_after_fr", fr_at(fa, 0), {1'b0, 14'd1});

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
